lc3b_mem_responder: RTL
=======================

// Module: lc3b_mem_responder
// PURPOSE
//  Memory-side responder for the LC-3b CPU memory interface. Answers mem_read/mem_write with a
//  single-cycle mem_resp after a fixed, parameterised latency. Backed by an internal word array
//  with per-byte write enables. Sits between the CPU top level and the bench or FPGA fabric.
// PARAMETERS
//  ADDR_WIDTH  12  word-address bits; the array holds 2**ADDR_WIDTH 16-bit words
//  LATENCY     4   cycles from request acceptance to the mem_resp pulse; legal range 1..15
// PORTS
//  clk              in   1   rising-edge clock
//  rst_n            in   1   async active-low reset
//  mem_read         in   1   read request; held by CPU until mem_resp
//  mem_write        in   1   write request; held by CPU until mem_resp
//  mem_byte_enable  in   2   [0]=low byte, [1]=high byte; writes only
//  mem_address      in   16  byte address; bit 0 is ignored for word select
//  mem_wdata        in   16  write data
//  mem_resp         out  1   one-cycle completion pulse
//  mem_rdata        out  16  read data; valid in the mem_resp cycle and held until the next read completes
//  mem_misaligned   out  1   only when MEM_ALIGN_CHECK_EN is defined (see CONFIGURATION)
// BEHAVIOUR
//  - Reset, one clock, asynchronous and active-low: state=IDLE, counter=0, mem_resp=0,
//    mem_rdata=16'h0000, mem_misaligned=0. Array contents are not reset.
//  - FSM states IDLE, BUSY, RESP.
//  - IDLE: if mem_read|mem_write, capture op, address, wdata and byte_enable into request
//    registers, load counter=LATENCY-1, then go to BUSY. If LATENCY==1, go directly to RESP.
//  - BUSY: decrement counter; when counter==1, go to RESP.
//  - RESP: perform the access using the captured values. Assert mem_resp=1 for exactly this cycle.
//    - Read: mem_rdata <= array[addr[ADDR_WIDTH:1]]. The register is updated on entering RESP,
//      so the data is visible in the same cycle as mem_resp.
//    - Write: bytes with enable set are written at the RESP clock edge.
//    - Then go to IDLE. A new request is accepted no earlier than the cycle after RESP.
//  - Latency: request sampled at edge 0 -> mem_resp high in cycle LATENCY.
//  - Addressing: word index = mem_address[ADDR_WIDTH:1]. Upper bits are ignored, so the address
//    space aliases and wraps modulo 2**(ADDR_WIDTH+1) bytes.
//  - Reads return the full word regardless of byte_enable; the CPU byte-selects.
//  - mem_read & mem_write both high in IDLE: treated as a write.
//  - A write with byte_enable==2'b00 leaves the array unchanged and still pulses mem_resp.
//  - Request dropped during BUSY: the captured access still completes and mem_resp still pulses.
//    Inputs are not re-sampled until IDLE.
//  - rst_n asserted mid-operation: immediate return to IDLE and no mem_resp. A pending write
//    is discarded.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN
//    Defined: adds output mem_misaligned. It is sticky and set in RESP when a write has
//    byte_enable==2'b11 and address[0]==1. It clears only on reset. The access still performs
//    as a word access.
//    Undefined: the port and its logic are absent.
// STRUCTURE
//  - lc3b_types additions:
//    - typedef logic [1:0] lc3b_mem_be
//    - typedef enum {MEM_IDLE, MEM_BUSY, MEM_RESP} lc3b_memstate
//    - localparam lc3b_word MEM_RESET_DATA = 16'h0000
//    - Ports reuse lc3b_word.
//  - Sub-module mem_array, parameterised on ADDR_WIDTH: combinational read port plus
//    synchronous write with 2-bit byte write-enable. The FSM, request registers and counter
//    live in lc3b_mem_responder.
// TESTING
//  1. Preload [0x0010]=16'hBEEF. Read addr 16'h0020 with LATENCY=4 -> mem_resp in cycle 4 only,
//     and mem_rdata=16'hBEEF.
//  2. Write 16'h1234 with be=2'b01 to 16'h0020, then read it back -> 16'hBE34.
//     Write 16'hAB00 with be=2'b10 -> readback 16'hAB34.
//  3. Back-to-back: hold a read, then assert the next read the cycle after mem_resp -> both
//     complete, with resp pulses separated by LATENCY+1 cycles.
//  4. Assert rst_n low in BUSY of a write of 16'hFFFF -> no mem_resp; a later readback shows
//     the old value; mem_rdata=0.
//  5. mem_read&mem_write both high with wdata=16'h5A5A -> the location holds 16'h5A5A.
//     Also check aliasing: address 16'h2020 with ADDR_WIDTH=12 hits the same word as 16'h0020.
//  6. With MEM_ALIGN_CHECK_EN: word write at 16'h0021 -> mem_misaligned=1 and stays 1 until
//     rst_n. Without the macro: the build has no such port.

Source files
------------

// File: rtl/lc3b_mem_responder_pkg.sv
// Shared types for the LC-3b memory responder: data word, byte enables, FSM states.
`timescale 1ns/1ps
package lc3b_mem_responder_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_be;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_BUSY,
        MEM_RESP
    } lc3b_memstate;

    localparam lc3b_word MEM_RESET_DATA = 16'h0000;

endpackage

// File: rtl/lc3b_mem_responder_mem_array.sv
// Word array for the memory responder: combinational read port, synchronous byte-enabled write.
`timescale 1ns/1ps
module mem_array
    import lc3b_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output lc3b_word              rdata,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  lc3b_mem_be            we,
    input  lc3b_word              wdata
);

    lc3b_word mem [2**ADDR_WIDTH];

    always_comb begin
        rdata = mem[raddr];
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we[0]) mem[waddr][7:0]  <= wdata[7:0];
        if (we[1]) mem[waddr][15:8] <= wdata[15:8];
    end

endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory-side responder: fixed-latency single-pulse mem_resp over an internal word array.
// Optional build macro MEM_ALIGN_CHECK_EN adds the sticky mem_misaligned output.
`timescale 1ns/1ps
module lc3b_mem_responder
    import lc3b_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mem_read,
    input  logic       mem_write,
    input  lc3b_mem_be mem_byte_enable,
    input  lc3b_word   mem_address,
    input  lc3b_word   mem_wdata,
    output logic       mem_resp,
    output lc3b_word   mem_rdata
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic       mem_misaligned
`endif
);

    lc3b_memstate          state;
    logic [3:0]            counter;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_idx;
    lc3b_word              req_wdata;
    lc3b_mem_be            req_be;
`ifdef MEM_ALIGN_CHECK_EN
    logic                  req_lsb;
`endif

    logic [ADDR_WIDTH-1:0] rd_idx;
    lc3b_word              arr_rdata;
    lc3b_mem_be            arr_we;
    logic                  unused_addr_bits;

    // With LATENCY==1 the read data is loaded on the accepting edge, so index straight from the bus.
    always_comb begin
        rd_idx           = (state == MEM_IDLE) ? mem_address[ADDR_WIDTH:1] : req_idx;
        arr_we           = (state == MEM_RESP && req_write) ? req_be : '0;
        unused_addr_bits = ^{mem_address[15:ADDR_WIDTH+1], mem_address[0]};
    end

    mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .raddr(rd_idx),
        .rdata(arr_rdata),
        .waddr(req_idx),
        .we   (arr_we),
        .wdata(req_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MEM_IDLE;
            counter   <= '0;
            mem_resp  <= 1'b0;
            mem_rdata <= MEM_RESET_DATA;
            req_write <= 1'b0;
            req_idx   <= '0;
            req_wdata <= '0;
            req_be    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            req_lsb        <= 1'b0;
            mem_misaligned <= 1'b0;
`endif
        end else begin
            case (state)
                MEM_IDLE: begin
                    mem_resp <= 1'b0;
                    if (mem_read || mem_write) begin
                        req_write <= mem_write;
                        req_idx   <= mem_address[ADDR_WIDTH:1];
                        req_wdata <= mem_wdata;
                        req_be    <= mem_byte_enable;
`ifdef MEM_ALIGN_CHECK_EN
                        req_lsb   <= mem_address[0];
`endif
                        counter   <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state    <= MEM_RESP;
                            mem_resp <= 1'b1;
                            if (!mem_write) mem_rdata <= arr_rdata;
                        end else begin
                            state <= MEM_BUSY;
                        end
                    end
                end
                MEM_BUSY: begin
                    counter <= counter - 4'd1;
                    if (counter == 4'd1) begin
                        state    <= MEM_RESP;
                        mem_resp <= 1'b1;
                        if (!req_write) mem_rdata <= arr_rdata;
                    end
                end
                MEM_RESP: begin
                    mem_resp <= 1'b0;
                    state    <= MEM_IDLE;
`ifdef MEM_ALIGN_CHECK_EN
                    if (req_write && req_be == 2'b11 && req_lsb) mem_misaligned <= 1'b1;
`endif
                end
                default: begin
                    mem_resp <= 1'b0;
                    state    <= MEM_IDLE;
                end
            endcase
        end
    end

endmodule
